conv_pool_layer: RTL

- Parametrised single-layer convolution engine with a fused 2x2 max-pool stage.
- Consumes one raster-order pixel stream and computes CH independent KxK valid convolutions, adding a per-channel bias.
- Each convolution result goes through optional ReLU, then 2x2/stride-2 max pooling; pooled words for all channels are emitted together.
- Next-generation replacement for the fixed 6-channel, 16-bit first layer: feeds the following layer directly and supports runtime-loadable weights and biases.

---
 rtl/conv_pool_layer.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_pool_layer.sv
// Multi-channel KxK valid convolution with per-channel bias and saturation, fused 2x2/stride-2 max-pool.
// Optional feature macro: RELU_EN clamps negative conv results to zero before pooling.
module conv_pool_layer #(
    parameter int CH   = 6,
    parameter int DW   = 16,
    parameter int IMG  = 28,
    parameter int K    = 5,
    parameter int FRAC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wen,
    input  logic [CH*DW-1:0] wdata,
    input  logic             bias_wen,
    input  logic [CH*DW-1:0] bias_in,
    input  logic             din_valid,
    input  logic [DW-1:0]    din,
    output logic [CH*DW-1:0] dout,
    output logic             dout_valid,
    output logic             frame_done,
    output logic             busy
);
    localparam int KK  = K * K;
    localparam int OW  = IMG - K + 1;
    localparam int PW  = OW / 2;
    localparam int AW  = 2 * DW + $clog2(KK);
    localparam int CW  = $clog2(IMG);
    localparam int TW  = $clog2(KK);
    localparam int PAW = (PW > 1) ? $clog2(PW) : 1;

    localparam logic [CW-1:0] LAST_POS = CW'(IMG - 1);
    localparam logic [CW-1:0] WIN_POS  = CW'(K - 1);
    localparam logic [TW-1:0] LAST_TAP = TW'(KK - 1);
    localparam logic signed [DW-1:0] ZERO_W = {DW{1'b0}};
    localparam logic signed [AW:0] SAT_HI = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] SAT_LO = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic signed [DW-1:0] sat_fn(input logic signed [AW:0] v);
        logic signed [DW-1:0] r;
        if (v > SAT_HI) begin
            r = SAT_HI[DW-1:0];
        end else if (v < SAT_LO) begin
            r = SAT_LO[DW-1:0];
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [DW-1:0] relu_fn(input logic signed [DW-1:0] v);
`ifdef RELU_EN
        return v[DW-1] ? ZERO_W : v;
`else
        return v;
`endif
    endfunction

    function automatic logic signed [DW-1:0] max_fn(input logic signed [DW-1:0] a,
                                                    input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t                state_r;
    logic [TW-1:0]         tap_cnt_r;
    logic                  busy_r;
    logic                  tail_r;
    logic signed [DW-1:0]  w_r    [CH][KK];
    logic signed [DW-1:0]  bias_r [CH];

    logic [CW-1:0]         col_r;
    logic [CW-1:0]         row_r;
    logic signed [DW-1:0]  lb_r   [K-1][IMG];
    logic signed [DW-1:0]  win_r  [K][K];
    logic signed [DW-1:0]  col_s  [K];
    logic                  s1_go_r;
    logic [CW-1:0]         s1_j_r;
    logic                  s1_iodd_r;
    logic                  s1_last_r;

    logic signed [DW-1:0]  res_s  [CH];
    logic signed [DW-1:0]  conv_r [CH];
    logic                  s2_go_r;
    logic [CW-1:0]         s2_j_r;
    logic                  s2_iodd_r;
    logic                  s2_last_r;

    logic [PAW-1:0]        pidx_s;
    logic signed [DW-1:0]  pair_s [CH];
    logic signed [DW-1:0]  pool_s [CH];
    logic signed [DW-1:0]  hmax_r [CH];
    logic signed [DW-1:0]  pbuf_r [CH][PW];
    logic [CH*DW-1:0]      dout_r;
    logic                  dout_valid_r;
    logic                  last_out_r;
    logic                  frame_done_r;

    logic accept_s;
    logic wen_ok_s;
    logic bias_ok_s;
    logic last_pix_s;
    logic pool_last_s;

    // Once the final pixel is in, the stream is closed until the frame drains.
    assign accept_s    = din_valid && ((state_r == ST_IDLE) || ((state_r == ST_RUN) && !tail_r));
    assign wen_ok_s    = wen && (state_r != ST_RUN);
    assign bias_ok_s   = bias_wen && (state_r != ST_RUN);
    assign last_pix_s  = (row_r == LAST_POS) && (col_r == LAST_POS);
    assign pool_last_s = dout_valid_r && last_out_r;

    // Control FSM: tap counter, state, busy flag and end-of-stream tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            tap_cnt_r <= {TW{1'b0}};
            busy_r    <= 1'b0;
            tail_r    <= 1'b0;
        end else begin
            if (wen_ok_s) begin
                tap_cnt_r <= (tap_cnt_r == LAST_TAP) ? {TW{1'b0}} : tap_cnt_r + TW'(1);
            end
            if (accept_s && last_pix_s) begin
                tail_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else if (wen_ok_s && (tap_cnt_r != LAST_TAP)) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (wen_ok_s && (tap_cnt_r == LAST_TAP)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (pool_last_s) begin
                        busy_r <= 1'b0;
                    end
                    if (frame_done_r) begin
                        state_r <= ST_IDLE;
                        tail_r  <= 1'b0;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Weight and bias storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < CH; ch++) begin
                bias_r[ch] <= ZERO_W;
                for (int t = 0; t < KK; t++) begin
                    w_r[ch][t] <= ZERO_W;
                end
            end
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                if (wen_ok_s) begin
                    w_r[ch][tap_cnt_r] <= wdata[(CH-1-ch)*DW +: DW];
                end
                if (bias_ok_s) begin
                    bias_r[ch] <= bias_in[(CH-1-ch)*DW +: DW];
                end
            end
        end
    end

    // New window column: oldest buffered row at index 0, incoming pixel at K-1
    always_comb begin
        for (int a = 0; a < K; a++) begin
            col_s[a] = din;
        end
        for (int a = 0; a < K-1; a++) begin
            col_s[a] = lb_r[K-2-a][col_r];
        end
    end

    // Pixel front end: raster counters, line buffers, sliding window, position tags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_r     <= {CW{1'b0}};
            row_r     <= {CW{1'b0}};
            s1_go_r   <= 1'b0;
            s1_j_r    <= {CW{1'b0}};
            s1_iodd_r <= 1'b0;
            s1_last_r <= 1'b0;
            for (int k = 0; k < K-1; k++) begin
                for (int c = 0; c < IMG; c++) begin
                    lb_r[k][c] <= ZERO_W;
                end
            end
            for (int a = 0; a < K; a++) begin
                for (int b = 0; b < K; b++) begin
                    win_r[a][b] <= ZERO_W;
                end
            end
        end else begin
            s1_go_r <= 1'b0;
            if (accept_s) begin
                col_r <= (col_r == LAST_POS) ? {CW{1'b0}} : col_r + CW'(1);
                if (col_r == LAST_POS) begin
                    row_r <= (row_r == LAST_POS) ? {CW{1'b0}} : row_r + CW'(1);
                end
                lb_r[0][col_r] <= din;
                for (int k = 1; k < K-1; k++) begin
                    lb_r[k][col_r] <= lb_r[k-1][col_r];
                end
                for (int a = 0; a < K; a++) begin
                    for (int b = 0; b < K-1; b++) begin
                        win_r[a][b] <= win_r[a][b+1];
                    end
                    win_r[a][K-1] <= col_s[a];
                end
                s1_go_r   <= (row_r >= WIN_POS) && (col_r >= WIN_POS);
                s1_j_r    <= col_r - WIN_POS;
                s1_iodd_r <= row_r[0] ^ WIN_POS[0];
                s1_last_r <= last_pix_s;
            end
        end
    end

    // Multiply-accumulate, floor rescale, bias, saturation and optional ReLU
    always_comb begin
        logic signed [AW-1:0] sum_v;
        sum_v = {AW{1'b0}};
        for (int ch = 0; ch < CH; ch++) begin
            sum_v = {AW{1'b0}};
            for (int t = 0; t < KK; t++) begin
                sum_v = sum_v + AW'(w_r[ch][t]) * AW'(win_r[t / K][t % K]);
            end
            res_s[ch] = relu_fn(sat_fn((AW+1)'(sum_v >>> FRAC) + (AW+1)'(bias_r[ch])));
        end
    end

    // Conv result register, one cycle behind the completing pixel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_go_r   <= 1'b0;
            s2_j_r    <= {CW{1'b0}};
            s2_iodd_r <= 1'b0;
            s2_last_r <= 1'b0;
            for (int ch = 0; ch < CH; ch++) begin
                conv_r[ch] <= ZERO_W;
            end
        end else begin
            s2_go_r <= s1_go_r;
            if (s1_go_r) begin
                s2_j_r    <= s1_j_r;
                s2_iodd_r <= s1_iodd_r;
                s2_last_r <= s1_last_r;
                for (int ch = 0; ch < CH; ch++) begin
                    conv_r[ch] <= res_s[ch];
                end
            end
        end
    end

    // Horizontal pair max, then combined with the stored upper-row pair
    always_comb begin
        pidx_s = PAW'(s2_j_r[CW-1:1]);
        for (int ch = 0; ch < CH; ch++) begin
            pair_s[ch] = max_fn(hmax_r[ch], conv_r[ch]);
            pool_s[ch] = max_fn(pbuf_r[ch][pidx_s], pair_s[ch]);
        end
    end

    // 2x2 max-pool state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r       <= {(CH*DW){1'b0}};
            dout_valid_r <= 1'b0;
            last_out_r   <= 1'b0;
            frame_done_r <= 1'b0;
            for (int ch = 0; ch < CH; ch++) begin
                hmax_r[ch] <= ZERO_W;
                for (int p = 0; p < PW; p++) begin
                    pbuf_r[ch][p] <= ZERO_W;
                end
            end
        end else begin
            dout_valid_r <= 1'b0;
            frame_done_r <= pool_last_s;
            if (s2_go_r) begin
                for (int ch = 0; ch < CH; ch++) begin
                    if (!s2_j_r[0]) begin
                        hmax_r[ch] <= conv_r[ch];
                    end else if (!s2_iodd_r) begin
                        pbuf_r[ch][pidx_s] <= pair_s[ch];
                    end else begin
                        dout_r[(CH-1-ch)*DW +: DW] <= pool_s[ch];
                    end
                end
                dout_valid_r <= s2_j_r[0] & s2_iodd_r;
                last_out_r   <= s2_last_r;
            end
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule
